// File: rtl/mii_frame_checker.sv
// mii_frame_checker
// Watches a 64-bit block stream with one control flag per byte lane.
// Frames open on a start block, close on a terminate block in lane 0, and
// abort on any other control block. Header fields, payload length and
// per-frame error flags are reported with a one-cycle done/ok pulse.
// Good and bad frames are tallied in wrapping 16-bit counters.
module mii_frame_checker #(
    parameter int          DATA_WIDTH        = 64,
    parameter int          CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter logic [47:0] EXP_DST_ADDR      = 48'h0180C2000001,
    parameter int          MIN_PAYLOAD       = 46,
    parameter int          MAX_PAYLOAD       = 1500,
    parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
    parameter logic [7:0]  FCS_CODE          = 8'hC0,
    parameter logic [7:0]  START_CODE        = 8'hFB,
    parameter logic [7:0]  PREAMBLE_CODE     = 8'h55,
    parameter logic [7:0]  SFD_CODE          = 8'hD5,
    parameter logic [7:0]  TERMINATE_CODE    = 8'hFD,
    parameter logic [7:0]  IDLE_CODE         = 8'h07
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_frame_ok,
    output logic [7:0]            o_err_flags,
    output logic [15:0]           o_payload_len,
    output logic [47:0]           o_dst_addr,
    output logic [47:0]           o_src_addr,
    output logic [15:0]           o_len_typ,
    output logic [15:0]           o_good_cnt,
    output logic [15:0]           o_bad_cnt
);

    // Only the 64-bit datapath exists, and the control codes must be
    // distinct or block classification becomes ambiguous.
    if (DATA_WIDTH != 64 || IDLE_CODE == START_CODE || IDLE_CODE == TERMINATE_CODE
        || START_CODE == TERMINATE_CODE) begin : g_param_check
        $error("mii_frame_checker: unsupported width or overlapping control codes");
    end

    localparam logic [15:0] MIN_LEN = 16'(MIN_PAYLOAD);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR_DA  = 2'd1,
        S_HDR_SA  = 2'd2,
        S_PAYLOAD = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    // Per-frame context
    logic [15:0]  r_nblk;        // data blocks seen since the start block
    logic [7:0]   r_err;         // errors accumulated while the frame is open
    logic [63:0]  r_hold;        // one-block holdback of the latest data block
    logic         r_hold_is_sa;  // held block is the SA/LT block (only lanes 6-7 payload)
    logic [47:0]  r_da;
    logic [47:0]  r_sa;
    logic [15:0]  r_lt;

    // Reported results
    logic         r_done;
    logic         r_ok;
    logic [7:0]   r_err_flags;
    logic [15:0]  r_payload_len;
    logic [47:0]  r_dst_addr;
    logic [47:0]  r_src_addr;
    logic [15:0]  r_len_typ;
    logic [15:0]  r_good_cnt;
    logic [15:0]  r_bad_cnt;

    // Block classification and decisions
    logic         w_is_start;
    logic         w_is_term;
    logic         w_is_data;
    logic         w_pre_ok;
    logic [15:0]  w_len;
    logic         w_close;
    logic [7:0]   w_close_err;
    logic         w_open;
    logic         w_cap_da;
    logic         w_cap_sa;
    logic         w_shift;
    logic         w_pay_err;

    // Preamble bytes 1-6 and SFD in byte 7 following the start code.
    function automatic logic preamble_ok(input logic [63:0] d);
        logic ok;
        ok = (d[63:56] == SFD_CODE);
        for (int i = 1; i < 7; i++) begin
            if (d[8*i +: 8] != PREAMBLE_CODE) ok = 1'b0;
        end
        return ok;
    endfunction

    // Any selected lane that does not carry the payload pattern.
    function automatic logic payload_bad(input logic [63:0] d, input logic [7:0] lanes);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (lanes[i] && d[8*i +: 8] != DATA_CHAR_PATTERN) bad = 1'b1;
        end
        return bad;
    endfunction

    // FCS bytes occupy lanes 4-7 of the final data block.
    function automatic logic fcs_bad(input logic [63:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 4; i < 8; i++) begin
            if (d[8*i +: 8] != FCS_CODE) bad = 1'b1;
        end
        return bad;
    endfunction

    // Payload bytes = 8*N - 18 (14 header + 4 FCS), clamped to 16 bits.
    function automatic logic [15:0] calc_len(input logic [15:0] nblk);
        logic [19:0] bytes;
        logic [19:0] diff;
        bytes = {1'b0, nblk, 3'b000};
        diff  = bytes - 20'd18;
        if (bytes < 20'd18)
            return 16'h0000;
        else if (diff[19:16] != 4'h0)
            return 16'hFFFF;
        else
            return diff[15:0];
    endfunction

    // Saturating block count so a runaway frame still reports 16'hFFFF.
    function automatic logic [15:0] nblk_inc(input logic [15:0] n);
        return (n == 16'hFFFF) ? n : n + 16'd1;
    endfunction

    assign w_is_start = (i_rx_ctrl == 8'h01) && (i_rx_data[7:0] == START_CODE);
    assign w_is_term  = i_rx_ctrl[0] && (i_rx_data[7:0] == TERMINATE_CODE);
    assign w_is_data  = (i_rx_ctrl == 8'h00);
    assign w_pre_ok   = preamble_ok(i_rx_data);
    assign w_len      = calc_len(r_nblk);

    // State register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, frame open/close decisions and close-time error set
    always_comb begin
        w_state_nxt = r_state;
        w_close     = 1'b0;
        w_close_err = 8'h00;
        w_open      = 1'b0;
        w_cap_da    = 1'b0;
        w_cap_sa    = 1'b0;
        w_shift     = 1'b0;
        w_pay_err   = 1'b0;

        if (r_state == S_IDLE) begin
            if (w_is_start) begin
                w_open      = 1'b1;
                w_state_nxt = S_HDR_DA;
            end
        end else if (w_is_term) begin
            w_close     = 1'b1;
            w_state_nxt = S_IDLE;
            w_close_err = r_err;
            if (r_state != S_PAYLOAD || w_len < MIN_LEN) w_close_err[2] = 1'b1;
            if (w_len > MAX_LEN) w_close_err[3] = 1'b1;
            // With only the SA/LT block held there is no FCS block to inspect.
            if (r_state == S_PAYLOAD && !r_hold_is_sa) begin
                if (payload_bad(r_hold, 8'h0F)) w_close_err[6] = 1'b1;
                if (fcs_bad(r_hold))            w_close_err[5] = 1'b1;
            end
        end else if (!w_is_data) begin
            w_close     = 1'b1;
            w_close_err = r_err | 8'h10;
            if (w_is_start) begin
                w_open      = 1'b1;
                w_state_nxt = S_HDR_DA;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else begin
            case (r_state)
                S_HDR_DA: begin
                    w_cap_da    = 1'b1;
                    w_state_nxt = S_HDR_SA;
                end
                S_HDR_SA: begin
                    w_cap_sa    = 1'b1;
                    w_state_nxt = S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    w_shift   = 1'b1;
                    w_pay_err = payload_bad(r_hold, r_hold_is_sa ? 8'hC0 : 8'hFF);
                end
                default: ;
            endcase
        end
        w_close_err[7] = 1'b0;
    end

    // Frame context: header capture, holdback, block count and running errors
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_nblk       <= '0;
            r_err        <= '0;
            r_hold       <= '0;
            r_hold_is_sa <= 1'b0;
            r_da         <= '0;
            r_sa         <= '0;
            r_lt         <= '0;
        end else if (w_open) begin
            r_nblk       <= '0;
            r_err        <= {7'b0, ~w_pre_ok};
            r_hold       <= '0;
            r_hold_is_sa <= 1'b0;
            r_da         <= '0;
            r_sa         <= '0;
            r_lt         <= '0;
        end else if (w_cap_da) begin
            r_nblk     <= nblk_inc(r_nblk);
            r_da       <= i_rx_data[47:0];
            r_sa[15:0] <= i_rx_data[63:48];
            if (i_rx_data[47:0] != EXP_DST_ADDR) r_err[1] <= 1'b1;
        end else if (w_cap_sa) begin
            r_nblk       <= nblk_inc(r_nblk);
            r_sa[47:16]  <= i_rx_data[31:0];
            r_lt         <= i_rx_data[47:32];
            r_hold       <= i_rx_data;
            r_hold_is_sa <= 1'b1;
        end else if (w_shift) begin
            r_nblk       <= nblk_inc(r_nblk);
            r_hold       <= i_rx_data;
            r_hold_is_sa <= 1'b0;
            if (w_pay_err) r_err[6] <= 1'b1;
        end
    end

    // Close reporting: pulses every cycle, result fields held until next close
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_done        <= 1'b0;
            r_ok          <= 1'b0;
            r_err_flags   <= '0;
            r_payload_len <= '0;
            r_dst_addr    <= '0;
            r_src_addr    <= '0;
            r_len_typ     <= '0;
        end else begin
            r_done <= w_close;
            r_ok   <= w_close && (w_close_err == 8'h00);
            if (w_close) begin
                r_err_flags   <= w_close_err;
                r_payload_len <= w_len;
                r_dst_addr    <= r_da;
                r_src_addr    <= r_sa;
                r_len_typ     <= r_lt;
            end
        end
    end

    // Good/bad frame tallies, wrapping at 16 bits
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (w_close) begin
            if (w_close_err == 8'h00) r_good_cnt <= r_good_cnt + 16'd1;
            else                      r_bad_cnt  <= r_bad_cnt + 16'd1;
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = r_done;
    assign o_frame_ok    = r_ok;
    assign o_err_flags   = r_err_flags;
    assign o_payload_len = r_payload_len;
    assign o_dst_addr    = r_dst_addr;
    assign o_src_addr    = r_src_addr;
    assign o_len_typ     = r_len_typ;
    assign o_good_cnt    = r_good_cnt;
    assign o_bad_cnt     = r_bad_cnt;

endmodule

// File: tb/tb_mii_frame_checker.sv
// Testbench for mii_frame_checker: directed frames for the called-out cases
// followed by randomized frames, checked against a frame-level reference model.
module tb_mii_frame_checker;

    localparam logic [47:0] EXP_DA   = 48'h0180C2000001;
    localparam logic [63:0] START_OK = 64'hD5555555_555555FB;
    localparam logic [63:0] START_BD = 64'hD5555555_545555FB;
    localparam logic [63:0] IDLE_BLK = 64'h07070707_07070707;
    localparam logic [63:0] TERM_BLK = 64'h07070707_070707FD;
    localparam logic [63:0] DA_BLK   = {16'h5455, 48'h0180C2000001};
    localparam logic [63:0] SA_BLK   = 64'hAAAA8808_5A515253;
    localparam logic [63:0] AA_BLK   = 64'hAAAAAAAA_AAAAAAAA;
    localparam logic [63:0] FCS_BLK  = 64'hC0C0C0C0_AAAAAAAA;

    localparam int E_TERM  = 0;
    localparam int E_IDLE  = 1;
    localparam int E_START = 2;
    localparam int E_NONE  = 3;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [63:0] i_rx_data;
    logic [7:0]  i_rx_ctrl;
    logic        o_busy, o_frame_done, o_frame_ok;
    logic [7:0]  o_err_flags;
    logic [15:0] o_payload_len, o_len_typ, o_good_cnt, o_bad_cnt;
    logic [47:0] o_dst_addr, o_src_addr;

    mii_frame_checker dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_rx_data     (i_rx_data),
        .i_rx_ctrl     (i_rx_ctrl),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_frame_ok    (o_frame_ok),
        .o_err_flags   (o_err_flags),
        .o_payload_len (o_payload_len),
        .o_dst_addr    (o_dst_addr),
        .o_src_addr    (o_src_addr),
        .o_len_typ     (o_len_typ),
        .o_good_cnt    (o_good_cnt),
        .o_bad_cnt     (o_bad_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Expectations for the block being driven (n_*) and the one just sampled (p_*)
    logic        n_close = 0, p_close = 0;
    logic        n_busy = 0,  p_busy = 0;
    logic [7:0]  n_err = 0,   p_err = 0;
    logic [15:0] n_len = 0,   p_len = 0;
    logic [47:0] n_da = 0,    p_da = 0;
    logic [47:0] n_sa = 0,    p_sa = 0;
    logic [15:0] n_lt = 0,    p_lt = 0;
    logic [15:0] n_good = 0,  p_good = 0;
    logic [15:0] n_bad = 0,   p_bad = 0;
    logic [15:0] m_good = 0,  m_bad = 0;
    bit          open_pending = 0;
    logic [63:0] blks[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one block at the falling edge, first checking what the previous block produced.
    task automatic tick(input logic [63:0] d, input logic [7:0] c);
        @(negedge clk);
        chk("done", o_frame_done, p_close);
        chk("busy", o_busy, p_busy);
        if (p_close) begin
            chk("ok",   o_frame_ok, (p_err == 8'h00));
            chk("err",  o_err_flags, p_err);
            chk("len",  o_payload_len, p_len);
            chk("da",   o_dst_addr, p_da);
            chk("sa",   o_src_addr, p_sa);
            chk("lt",   o_len_typ, p_lt);
            chk("good", o_good_cnt, p_good);
            chk("bad",  o_bad_cnt, p_bad);
        end
        i_rx_data = d;
        i_rx_ctrl = c;
        p_close = n_close; p_busy = n_busy; p_err = n_err; p_len = n_len;
        p_da = n_da; p_sa = n_sa; p_lt = n_lt; p_good = n_good; p_bad = n_bad;
        n_close = 0;
    endtask

    // Frame-level reference: results from the list of data blocks and how the frame ended.
    task automatic model_close(input bit pre_bad, input bit term);
        int          n;
        int          plen;
        logic [7:0]  e;
        logic [63:0] d;
        n    = blks.size();
        plen = 8 * n - 18;
        if (plen < 0) plen = 0;
        if (plen > 65535) plen = 65535;
        e = 8'h00;
        e[0] = pre_bad;
        if (n >= 1 && blks[0][47:0] != EXP_DA) e[1] = 1'b1;
        // Blocks 1..n-2 had a successor, so their payload lanes were inspected.
        for (int i = 1; i <= n - 2; i++) begin
            d = blks[i];
            for (int k = (i == 1 ? 6 : 0); k < 8; k++)
                if (d[8*k +: 8] != 8'hAA) e[6] = 1'b1;
        end
        if (term) begin
            if (plen < 46) e[2] = 1'b1;
            if (plen > 1500) e[3] = 1'b1;
            if (n >= 3) begin
                d = blks[n-1];
                for (int k = 0; k < 4; k++) if (d[8*k +: 8] != 8'hAA) e[6] = 1'b1;
                for (int k = 4; k < 8; k++) if (d[8*k +: 8] != 8'hC0) e[5] = 1'b1;
            end
        end else begin
            e[4] = 1'b1;
        end
        n_err = e;
        n_len = 16'(plen);
        n_da  = (n >= 1) ? blks[0][47:0] : 48'h0;
        n_sa  = (n >= 2) ? {blks[1][31:0], blks[0][63:48]} :
                (n == 1) ? {32'h0, blks[0][63:48]} : 48'h0;
        n_lt  = (n >= 2) ? blks[1][47:32] : 16'h0;
        if (e == 8'h00) m_good = m_good + 16'd1;
        else            m_bad  = m_bad + 16'd1;
        n_good  = m_good;
        n_bad   = m_bad;
        n_close = 1'b1;
    endtask

    // cm: 0 clean, 1 random byte corruption, 2 all-zero block at index 3
    task automatic send_frame(input int n, input int endk, input bit pre_bad, input int cm);
        logic [63:0] d;
        bit          pb;
        int          k;
        blks.delete();
        pb = open_pending ? 1'b0 : pre_bad;
        if (!open_pending) begin
            n_busy = 1'b1;
            tick(pb ? START_BD : START_OK, 8'h01);
        end
        open_pending = 0;
        for (int i = 0; i < n; i++) begin
            if (i == 0)                                   d = DA_BLK;
            else if (i == 1)                              d = SA_BLK;
            else if (i == n - 1 && endk == E_TERM)        d = FCS_BLK;
            else                                          d = AA_BLK;
            if (cm == 2 && i == 3) d = 64'h0;
            if (cm == 1 && $urandom_range(0, 11) == 0) begin
                k = $urandom_range(0, 7);
                d[8*k +: 8] = 8'($urandom);
            end
            blks.push_back(d);
            n_busy = 1'b1;
            tick(d, 8'h00);
        end
        if (endk == E_NONE) return;
        model_close(pb, endk == E_TERM);
        if (endk == E_TERM) begin
            n_busy = 1'b0;
            tick(TERM_BLK, 8'($urandom) | 8'h01);
        end else if (endk == E_IDLE) begin
            n_busy = 1'b0;
            tick(IDLE_BLK, 8'hFF);
        end else begin
            n_busy = 1'b1;
            tick(START_OK, 8'h01);
            open_pending = 1;
        end
    endtask

    // Blocks between frames: idle, stray terminate or stray data, all ignored.
    task automatic gap(input int cnt);
        int r;
        for (int i = 0; i < cnt; i++) begin
            r = $urandom_range(0, 2);
            n_busy = 1'b0;
            if (r == 0)      tick(IDLE_BLK, 8'hFF);
            else if (r == 1) tick(TERM_BLK, 8'hFF);
            else             tick({$urandom, $urandom}, 8'h00);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, o_frame_done, 0);
        chk({tag, "_ok"},   o_frame_ok, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_err"},  o_err_flags, 0);
        chk({tag, "_len"},  o_payload_len, 0);
        chk({tag, "_da"},   o_dst_addr, 0);
        chk({tag, "_sa"},   o_src_addr, 0);
        chk({tag, "_lt"},   o_len_typ, 0);
        chk({tag, "_good"}, o_good_cnt, 0);
        chk({tag, "_bad"},  o_bad_cnt, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        i_rst = 1'b1;
        i_rx_data = IDLE_BLK;
        i_rx_ctrl = 8'hFF;
        #1;
        chk_all_zero(tag);
        @(negedge clk);
        chk_all_zero(tag);
        i_rst = 1'b0;
        p_close = 0; p_busy = 0; n_close = 0; n_busy = 0;
        m_good = 0; m_bad = 0; open_pending = 0;
    endtask

    initial begin
        int r, n, endk;
        i_rst = 1'b1;
        i_rx_data = IDLE_BLK;
        i_rx_ctrl = 8'hFF;
        do_reset("por");

        // Nominal frame
        send_frame(8, E_TERM, 0, 0); gap(1);
        chk("nom_err", o_err_flags, 8'h00);
        chk("nom_len", o_payload_len, 16'd46);
        chk("nom_da", o_dst_addr, 48'h0180C2000001);
        chk("nom_sa", o_src_addr, 48'h5A5152535455);
        chk("nom_lt", o_len_typ, 16'h8808);
        chk("nom_good", o_good_cnt, 16'd1);

        // One payload block of zeros
        send_frame(8, E_TERM, 0, 2); gap(1);
        chk("zero_err", o_err_flags, 8'h40);
        chk("zero_len", o_payload_len, 16'd46);
        chk("zero_bad", o_bad_cnt, 16'd1);

        // Terminate right after the SA block
        send_frame(2, E_TERM, 0, 0); gap(1);
        chk("runt_err", o_err_flags, 8'h04);
        chk("runt_len", o_payload_len, 16'd0);

        // Idle block in place of the 4th payload block, then a clean frame
        send_frame(5, E_IDLE, 0, 0); gap(1);
        chk("abort_bit4", o_err_flags[4], 1'b1);
        send_frame(8, E_TERM, 0, 0); gap(1);
        chk("after_abort_err", o_err_flags, 8'h00);

        // Corrupted preamble
        send_frame(8, E_TERM, 1, 0); gap(1);
        chk("pre_err", o_err_flags, 8'h01);
        chk("pre_len", o_payload_len, 16'd46);

        // Shortest oversize frame and longest legal one
        send_frame(190, E_TERM, 0, 0); gap(1);
        chk("over_err", o_err_flags, 8'h08);
        chk("over_len", o_payload_len, 16'd1502);
        send_frame(189, E_TERM, 0, 0); gap(1);
        chk("max_err", o_err_flags, 8'h00);

        // Start block aborts an open frame and opens the next one
        send_frame(6, E_START, 0, 0);
        send_frame(8, E_TERM, 0, 0); gap(1);
        chk("restart_err", o_err_flags, 8'h00);

        // Terminate immediately after start
        send_frame(0, E_TERM, 0, 0); gap(2);
        chk("t0_err", o_err_flags, 8'h04);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       n = $urandom_range(0, 3);
            else if (r < 18) n = $urandom_range(188, 191);
            else             n = $urandom_range(6, 24);
            r = $urandom_range(0, 99);
            endk = (r < 70) ? E_TERM : (r < 85) ? E_IDLE : E_START;
            send_frame(n, endk, ($urandom_range(0, 9) == 0), 1);
            if (!open_pending) gap($urandom_range(0, 3));
        end
        if (open_pending) send_frame(8, E_TERM, 0, 0);
        gap(2);

        // Reset in the middle of a payload discards the frame silently
        send_frame(5, E_NONE, 0, 0);
        do_reset("mid_rst");
        gap(2);
        send_frame(8, E_TERM, 0, 0); gap(1);
        chk("rst_good", o_good_cnt, 16'd1);
        chk("rst_bad", o_bad_cnt, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
